// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C loopback subsystem.
package i2c_pkg;

  // Each bit period: one cycle with SCL low, one cycle with SCL high.
  localparam int BIT_CYCLES = 2;
  // Last counter value of an 8-bit address or data phase.
  localparam logic [3:0] PHASE_LAST = 4'(8 * BIT_CYCLES - 1);

  // Value of the R/W bit on the wire.
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef enum logic [2:0] {
    M_IDLE,
    M_START,
    M_ADDR,
    M_AACK,
    M_DATA,
    M_DACK,
    M_STOP_WAIT,
    M_STOP
  } m_state_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_AACK,
    S_WRITE,
    S_WACK,
    S_READ,
    S_RNACK
  } s_state_e;

endpackage

// File: rtl/i2c_master_fsm.sv
// Bit-level I2C master: one single-byte write or read per transaction.
// All bus outputs are registered; SCL is owned entirely by this block.
module i2c_master_fsm
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       chk_i,
  input  logic [7:0] din_i,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       sda_oe_o,
  output logic       done_o,
  output logic       ack_o,
  output logic [7:0] dout_o
);

  m_state_e   state_q;
  logic [3:0] cnt_q;
  logic [7:0] sh_q;
  logic       wr_q;
  logic       stop_pending_q;

  // Shift register advanced by one bit sampled from the bus.
  logic [7:0] sh_in;
  logic       stop_req;
  assign sh_in    = {sh_q[6:0], sda_i};
  assign stop_req = stop_pending_q | stop_i;

  // Transaction sequencer; the outputs set here describe the next cycle on the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= M_IDLE;
      cnt_q          <= '0;
      sh_q           <= '0;
      wr_q           <= 1'b0;
      stop_pending_q <= 1'b0;
      scl_o          <= 1'b1;
      sda_oe_o       <= 1'b0;
      done_o         <= 1'b0;
      ack_o          <= 1'b0;
      dout_o         <= '0;
    end else begin
      // NOTE: non-blocking assignments let every branch read the pre-edge
      // state, so the later clear of stop_pending_q cleanly wins over a set.
      done_o <= 1'b0;
      if (stop_i && state_q != M_IDLE) stop_pending_q <= 1'b1;

      case (state_q)
        M_IDLE: begin
          if (start_i) begin
            state_q <= M_START;
            cnt_q   <= '0;
            wr_q    <= chk_i;
            sh_q    <= {TARGET_ADDR, chk_i ? RW_WRITE : RW_READ};
          end
        end

        // Cycle 0 keeps SDA/SCL high, cycle 1 pulls SDA low under SCL high.
        M_START: begin
          if (cnt_q == 4'd0) begin
            cnt_q    <= 4'd1;
            sda_oe_o <= 1'b1;
          end else begin
            state_q  <= M_ADDR;
            cnt_q    <= '0;
            scl_o    <= 1'b0;
            sda_oe_o <= ~sh_q[7];
          end
        end

        // Even counts are SCL-low cycles, odd counts are SCL-high cycles.
        // Reads shift in from the bus; writes shift out the next MSB.
        M_ADDR, M_DATA: begin
          if (!cnt_q[0]) begin
            cnt_q <= cnt_q + 4'd1;
            scl_o <= 1'b1;
          end else begin
            sh_q  <= sh_in;
            scl_o <= 1'b0;
            if (cnt_q == PHASE_LAST) begin
              state_q  <= (state_q == M_ADDR) ? M_AACK : M_DACK;
              cnt_q    <= '0;
              sda_oe_o <= 1'b0;
            end else begin
              cnt_q    <= cnt_q + 4'd1;
              sda_oe_o <= (state_q == M_ADDR || wr_q) & ~sh_q[6];
            end
          end
        end

        M_AACK: begin
          if (cnt_q == 4'd0) begin
            cnt_q <= 4'd1;
            scl_o <= 1'b1;
          end else begin
            cnt_q <= '0;
            scl_o <= 1'b0;
            if (!sda_i) begin
              ack_o    <= 1'b1;
              state_q  <= M_DATA;
              sh_q     <= din_i;
              sda_oe_o <= wr_q & ~din_i[7];
            end else begin
              ack_o    <= 1'b0;
              done_o   <= 1'b1;
              state_q  <= M_STOP_WAIT;
              sda_oe_o <= 1'b1;
            end
          end
        end

        // Master leaves SDA released: slave ACK on writes, master NACK on reads.
        M_DACK: begin
          if (cnt_q == 4'd0) begin
            cnt_q <= 4'd1;
            scl_o <= 1'b1;
          end else begin
            cnt_q    <= '0;
            done_o   <= 1'b1;
            if (!wr_q) dout_o <= sh_q;
            state_q  <= M_STOP_WAIT;
            scl_o    <= 1'b0;
            sda_oe_o <= 1'b1;
          end
        end

        // SCL low with SDA low is the setup a STOP needs; when stop is already
        // pending this state lasts exactly that one setup cycle.
        M_STOP_WAIT: begin
          if (stop_req) begin
            state_q <= M_STOP;
            cnt_q   <= '0;
            scl_o   <= 1'b1;
          end
        end

        M_STOP: begin
          if (cnt_q == 4'd0) begin
            cnt_q    <= 4'd1;
            sda_oe_o <= 1'b0;
          end else begin
            state_q        <= M_IDLE;
            stop_pending_q <= 1'b0;
          end
        end

        default: state_q <= M_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/i2c_slave_fsm.sv
// I2C slave with one 8-bit data register. Bus events are decoded from the
// current SDA/SCL against the values registered one cycle earlier.
module i2c_slave_fsm
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic clk,
  input  logic rst,
  input  logic sda_i,
  input  logic scl_i,
  output logic sda_oe_o
);

  s_state_e   state_q;
  logic       sda_prev_q;
  logic       scl_prev_q;
  logic [7:0] sh_q;
  logic [7:0] data_q;
  logic [2:0] cnt_q;
  logic       rd_q;

  // START/STOP: SDA edge while SCL stays high across both samples.
  // bit_end: last cycle of an SCL-high period; the master drops SCL on this
  // same edge, so sampling here and updating SDA here keeps SDA changes
  // confined to SCL-low time.
  logic       start_det;
  logic       stop_det;
  logic       bit_end;
  logic [7:0] sh_in;
  assign start_det = scl_i & scl_prev_q & sda_prev_q & ~sda_i;
  assign stop_det  = scl_i & scl_prev_q & ~sda_prev_q & sda_i;
  assign bit_end   = scl_i & ~scl_prev_q;
  assign sh_in     = {sh_q[6:0], sda_i};

  // Protocol sequencer and data register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sda_prev_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sh_q       <= '0;
      // NOTE: the data register is architectural state with a defined reset
      // value, so it is reset along with the control registers.
      data_q     <= '0;
      cnt_q      <= '0;
      rd_q       <= 1'b0;
      sda_oe_o   <= 1'b0;
    end else begin
      sda_prev_q <= sda_i;
      scl_prev_q <= scl_i;

      if (start_det) begin
        state_q  <= S_ADDR;
        cnt_q    <= '0;
        sda_oe_o <= 1'b0;
      end else if (stop_det) begin
        state_q  <= S_IDLE;
        sda_oe_o <= 1'b0;
      end else if (bit_end) begin
        case (state_q)
          S_ADDR: begin
            sh_q  <= sh_in;
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (sh_in[7:1] == SLAVE_ADDR) begin
                state_q  <= S_AACK;
                rd_q     <= (sh_in[0] == RW_READ);
                sda_oe_o <= 1'b1;
              end else begin
                state_q <= S_IDLE;
              end
            end
          end

          S_AACK: begin
            cnt_q <= '0;
            if (rd_q) begin
              state_q  <= S_READ;
              sh_q     <= data_q;
              sda_oe_o <= ~data_q[7];
            end else begin
              state_q  <= S_WRITE;
              sda_oe_o <= 1'b0;
            end
          end

          S_WRITE: begin
            sh_q  <= sh_in;
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              data_q   <= sh_in;
              sda_oe_o <= 1'b1;
              state_q  <= S_WACK;
            end
          end

          S_WACK: begin
            sda_oe_o <= 1'b0;
            state_q  <= S_IDLE;
          end

          // Drive the next register bit; after the eighth bit release SDA so
          // the master's NACK slot is left alone.
          S_READ: begin
            sh_q  <= {sh_q[6:0], 1'b0};
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              sda_oe_o <= 1'b0;
              state_q  <= S_RNACK;
            end else begin
              sda_oe_o <= ~sh_q[6];
            end
          end

          S_RNACK: state_q <= S_IDLE;

          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/i2c_top.sv
// I2C loopback: internal master and slave on shared open-drain SDA/SCL nets.
module i2c_top
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter logic [6:0] TARGET_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       chk,
  input  logic [7:0] din,
  output logic       done,
  output logic       ack,
  output logic [7:0] dout
);

  logic m_scl;
  logic m_sda_oe;
  logic s_sda_oe;
  logic sda;
  logic scl;

  // Wired-AND bus: any enabled driver pulls the line low.
  assign sda = ~(m_sda_oe | s_sda_oe);
  assign scl = m_scl;

  i2c_master_fsm #(
    .TARGET_ADDR(TARGET_ADDR)
  ) u_master (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .stop_i  (stop),
    .chk_i   (chk),
    .din_i   (din),
    .sda_i   (sda),
    .scl_o   (m_scl),
    .sda_oe_o(m_sda_oe),
    .done_o  (done),
    .ack_o   (ack),
    .dout_o  (dout)
  );

  i2c_slave_fsm #(
    .SLAVE_ADDR(SLAVE_ADDR)
  ) u_slave (
    .clk     (clk),
    .rst     (rst),
    .sda_i   (sda),
    .scl_i   (scl),
    .sda_oe_o(s_sda_oe)
  );

endmodule

// File: tb/tb_i2c_top.sv
// Directed bench for the I2C loopback subsystem: a matching-address instance
// and a second instance whose master targets an address the slave ignores.
module tb_i2c_top;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       start_mm = 1'b0;
  logic       stop = 1'b0;
  logic       chk = 1'b0;
  logic [7:0] din = 8'h00;
  logic       done, ack;
  logic [7:0] dout;
  logic       done_mm, ack_mm;
  logic [7:0] dout_mm;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  i2c_top dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .stop (stop),
    .chk  (chk),
    .din  (din),
    .done (done),
    .ack  (ack),
    .dout (dout)
  );

  i2c_top #(
    .TARGET_ADDR(7'h51)
  ) dut_mm (
    .clk  (clk),
    .rst  (rst),
    .start(start_mm),
    .stop (stop),
    .chk  (chk),
    .din  (din),
    .done (done_mm),
    .ack  (ack_mm),
    .dout (dout_mm)
  );

  // Count SDA transitions that happen while SCL is high before and after;
  // only START and STOP may do that.
  logic sda_p  = 1'b1;
  logic scl_p  = 1'b1;
  int   hl_cnt = 0;
  always @(negedge clk) begin
    if (scl_p && dut.scl && (dut.sda !== sda_p)) hl_cnt <= hl_cnt + 1;
    sda_p <= dut.sda;
    scl_p <= dut.scl;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch a transaction (start sampled on the first edge) and count edges
  // until done; stop and a busy start are pulsed at the given edge indices.
  task automatic run(input bit mm, input bit wr, input logic [7:0] data,
                     input int stop_at, input int busy_at, output int cyc);
    chk = wr;
    din = data;
    if (mm) start_mm = 1'b1;
    else start = 1'b1;
    tick();
    start    = 1'b0;
    start_mm = 1'b0;
    cyc      = -1;
    for (int i = 1; i <= 100; i++) begin
      stop = (i == stop_at);
      if (i == busy_at) begin
        start = 1'b1;
        chk   = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      if ((mm ? done_mm : done) === 1'b1) begin
        cyc = i;
        break;
      end
    end
    stop  = 1'b0;
    start = 1'b0;
  endtask

  int cyc;
  int h0;
  int lowc;

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_done", done, 1'b0);
    check("rst_ack", ack, 1'b0);
    check("rst_dout", dout, 8'h00);
    check("rst_sda", dut.sda, 1'b1);
    check("rst_scl", dut.scl, 1'b1);
    rst = 1'b0;
    tick();

    // Write 0xCC with an early stop
    h0 = hl_cnt;
    run(1'b0, 1'b1, 8'hCC, 5, -1, cyc);
    check("wr_done_cycle", cyc, 38);
    check("wr_ack", ack, 1'b1);
    check("wr_dout_held", dout, 8'h00);
    check("wr_stopwait_scl", dut.scl, 1'b0);
    tick();
    check("wr_done_pulse", done, 1'b0);
    check("wr_stop0_scl", dut.scl, 1'b1);
    check("wr_stop0_sda", dut.sda, 1'b0);
    tick();
    check("wr_stop1_sda", dut.sda, 1'b1);
    tick();
    tick();
    check("wr_slave_reg", dut.u_slave.data_q, 8'hCC);
    check("wr_sda_rule", hl_cnt - h0, 2);

    // Read back 0xCC
    run(1'b0, 1'b0, 8'h00, 3, -1, cyc);
    check("rd_done_cycle", cyc, 38);
    check("rd_ack", ack, 1'b1);
    check("rd_dout", dout, 8'hCC);
    repeat (4) tick();

    // Write 0x3A, stop only 10 cycles after done
    run(1'b0, 1'b1, 8'h3A, -1, -1, cyc);
    check("late_done_cycle", cyc, 38);
    lowc = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (dut.scl === 1'b0) lowc++;
    end
    check("late_scl_held_low", lowc, 10);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("late_stop0_scl", dut.scl, 1'b1);
    check("late_stop0_sda", dut.sda, 1'b0);
    tick();
    check("late_stop1_sda", dut.sda, 1'b1);
    repeat (3) tick();
    check("late_slave_reg", dut.u_slave.data_q, 8'h3A);

    // Read with a write request injected mid-transaction
    h0 = hl_cnt;
    run(1'b0, 1'b0, 8'hFF, 4, 12, cyc);
    check("busy_done_cycle", cyc, 38);
    check("busy_ack", ack, 1'b1);
    check("busy_dout", dout, 8'h3A);
    repeat (4) tick();
    check("busy_sda_rule", hl_cnt - h0, 2);
    check("busy_slave_reg", dut.u_slave.data_q, 8'h3A);

    // Address mismatch on the second instance
    run(1'b1, 1'b1, 8'h77, 3, -1, cyc);
    check("mm_done_cycle", cyc, 20);
    check("mm_ack", ack_mm, 1'b0);
    repeat (6) tick();
    check("mm_slave_reg", dut_mm.u_slave.data_q, 8'h00);
    check("mm_dout", dout_mm, 8'h00);
    check("mm_idle_sda", dut_mm.sda, 1'b1);

    // Reset in the middle of the address phase
    chk   = 1'b1;
    din   = 8'h55;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    tick();
    check("midrst_done", done, 1'b0);
    check("midrst_ack", ack, 1'b0);
    check("midrst_dout", dout, 8'h00);
    check("midrst_sda", dut.sda, 1'b1);
    check("midrst_scl", dut.scl, 1'b1);
    check("midrst_slave_reg", dut.u_slave.data_q, 8'h00);
    rst = 1'b0;
    tick();

    // Normal operation after reset: write 0x96 and read it back
    run(1'b0, 1'b1, 8'h96, 2, -1, cyc);
    check("post_wr_done_cycle", cyc, 38);
    repeat (4) tick();
    run(1'b0, 1'b0, 8'h00, 2, -1, cyc);
    check("post_rd_done_cycle", cyc, 38);
    check("post_rd_dout", dout, 8'h96);
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
